// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// segment codes in {a,b,c,d,e,f,g} order, the dash code and default dividers.
package seg_scan_driver_pkg;

  localparam int SCAN_DIV_DEF  = 100000;
  localparam int BLINK_DIV_DEF = 256;

  localparam logic [6:0] SEG_0    = 7'h7E;
  localparam logic [6:0] SEG_1    = 7'h30;
  localparam logic [6:0] SEG_2    = 7'h6D;
  localparam logic [6:0] SEG_3    = 7'h79;
  localparam logic [6:0] SEG_4    = 7'h33;
  localparam logic [6:0] SEG_5    = 7'h5B;
  localparam logic [6:0] SEG_6    = 7'h5F;
  localparam logic [6:0] SEG_7    = 7'h70;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h7B;
  localparam logic [6:0] SEG_DASH = 7'h01;

  typedef logic [1:0] scan_idx_t;

  // A digit is a leading zero when it and every digit to its left are zero;
  // digit0 always stays visible so a value of 0 still shows "0".
  function automatic logic lz_blanked(logic [15:0] digits, scan_idx_t idx);
    return (idx != 2'd0) && ((digits >> {idx, 2'b00}) == 16'h0000);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus: digit/attribute inputs toward the driver and the
// multiplexed selector/segment outputs back from it.
interface seg_scan_driver_if;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  led_selector;
  logic [7:0]  led_data;

  modport master (
    output digits, dp_mask, blank_lz, blink_mask,
    input  led_selector, led_data
  );

  modport slave (
    input  digits, dp_mask, blank_lz, blink_mask,
    output led_selector, led_data
  );
endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with decimal points,
// leading-zero blanking and per-digit blinking.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic               clk,
  input  logic               button_rst,
  seg_scan_driver_if.slave   disp
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  scan_idx_t     idx_p0;
  logic [3:0]    led_sel_p1;
  logic [7:0]    led_data_p1;

  logic          tick;
  scan_idx_t     nxt_idx;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_seg;
  logic          suppress;

  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign nxt_idx  = idx_p0 + 2'd1;
  assign cur_bcd  = disp.digits[{nxt_idx, 2'b00} +: 4];
  assign suppress = (disp.blank_lz && lz_blanked(disp.digits, nxt_idx))
                  || (blink_phase && disp.blink_mask[nxt_idx]);

  bcd_to_seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // Stage p0 -> p1: the slot for the next index is built and registered on the tick edge
  always_ff @(posedge clk) begin
    if (button_rst) begin
      presc       <= '0;
      idx_p0      <= 2'd3;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      led_sel_p1  <= 4'b0000;
      led_data_p1 <= 8'h00;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx_p0      <= nxt_idx;
        led_sel_p1  <= 4'b0001 << nxt_idx;
        led_data_p1 <= suppress ? 8'h00 : {cur_seg, disp.dp_mask[nxt_idx]};
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign disp.led_selector = led_sel_p1;
  assign disp.led_data     = led_data_p1;

endmodule
